// File: rtl/cond_pkg.sv
// cond_pkg: condition codes, flag bit positions and flag-write enable positions
package cond_pkg;
  typedef enum logic [3:0] {
    COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
    COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
    COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
    COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
  } cond_e;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;
endpackage

// File: rtl/cond_unit_if.sv
// cond_unit_if: decoder/ALU-side controls into the conditional unit and gated controls out
interface cond_unit_if #(parameter int CNT_W = 8);
  logic             InstrValid;
  logic [3:0]       Cond;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagW;
  logic             PCS, RegW, MemW, NoWrite;
  logic             FlagSave, FlagRestore, CountClr;
  logic             PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] SkipCount;
  modport master (
    output InstrValid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
           FlagSave, FlagRestore, CountClr,
    input  PCSrc, RegWrite, MemWrite, CondEx, Flags, SkipCount
  );
  modport slave (
    input  InstrValid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
           FlagSave, FlagRestore, CountClr,
    output PCSrc, RegWrite, MemWrite, CondEx, Flags, SkipCount
  );
endinterface

// File: rtl/cond_check.sv
// cond_check: evaluates a 4-bit condition field against {N,Z,C,V}
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);
  logic n, z, c, v, base;
  assign {n, z, c, v} = {flags[FLAG_N], flags[FLAG_Z], flags[FLAG_C], flags[FLAG_V]};
  // odd codes are the inverse of the even code below them; AL inverted gives never
  always_comb begin
    base = 1'b1;
    case (cond_e'({cond[3:1], 1'b0}))
      COND_EQ: base = z;
      COND_CS: base = c;
      COND_MI: base = n;
      COND_VS: base = v;
      COND_HI: base = c & ~z;
      COND_GE: base = n == v;
      COND_GT: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
  end
  assign pass = base ^ cond[0];
endmodule

// File: rtl/cond_unit.sv
// cond_unit: flag register with shadow copy, condition gating of write-enables, skip counter
module cond_unit
  import cond_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  cond_unit_if.slave  bus
);
  logic [3:0]       flags, shadow;
  logic [CNT_W-1:0] cnt;
  logic             pass, cond_ex;
  cond_check u_check (.cond(bus.Cond), .flags(flags), .pass(pass));
  assign cond_ex       = bus.InstrValid & pass;
  assign bus.CondEx    = cond_ex;
  assign bus.PCSrc     = bus.PCS & cond_ex;
  assign bus.RegWrite  = bus.RegW & cond_ex & ~bus.NoWrite;
  assign bus.MemWrite  = bus.MemW & cond_ex;
  assign bus.Flags     = flags;
  assign bus.SkipCount = cnt;
  // restore overrides flag writes; save samples pre-edge flags, so both together swap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags  <= '0;
      shadow <= '0;
      cnt    <= '0;
    end else begin
      if (bus.FlagRestore) flags <= shadow;
      else begin
        if (cond_ex & bus.FlagW[FLAGW_NZ]) flags[FLAG_N:FLAG_Z] <= bus.ALUFlags[FLAG_N:FLAG_Z];
        if (cond_ex & bus.FlagW[FLAGW_CV]) flags[FLAG_C:FLAG_V] <= bus.ALUFlags[FLAG_C:FLAG_V];
      end
      if (bus.FlagSave) shadow <= flags;
      if (bus.CountClr) cnt <= '0;
      else if (bus.InstrValid & ~pass & ~&cnt) cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: doc/cond_unit.md
# cond_unit

Conditional-execution unit for the 5-bit ALU datapath: holds the architectural N/Z/C/V flag register, evaluates the 4-bit ARM-style condition field of each instruction against the stored flags, and gates the decoder's write-enables. It consumes the ALU's `ALUFlags` output, updates the flags on flag-setting instructions, keeps a one-entry shadow copy for exception save and restore, and counts condition-failed instructions. It sits between the ALU/decoder and the PC/register-file/memory write ports.

## Interface
- `CNT_W`, default 8, width of the skipped-instruction counter.
- `clk  in  1`  system clock, rising edge.
- `reset  in  1`  asynchronous, active-low reset.
- `InstrValid  in  1`  an instruction is present this cycle.
- `Cond  in  4`  condition field of the instruction.
- `ALUFlags  in  4`  flags from the ALU as {N,Z,C,V}, bit 3 = N.
- `FlagW  in  2`  flag-write request: [1] writes N,Z; [0] writes C,V.
- `PCS, RegW, MemW, NoWrite  in  1 each`  ungated decoder controls.
- `FlagSave, FlagRestore  in  1 each`  shadow-register pulses.
- `CountClr  in  1`  synchronous clear of the skip counter.
- `PCSrc, RegWrite, MemWrite  out  1 each`  gated controls.
- `CondEx  out  1`  condition passed.
- `Flags  out  4`  current stored {N,Z,C,V}.
- `SkipCount  out  CNT_W`  condition-failed instruction count.

## Operation
- Condition evaluation uses the stored `Flags`, not the `ALUFlags` input:
  - 0000 EQ: Z; 0001 NE: ~Z
  - 0010 CS: C; 0011 CC: ~C
  - 0100 MI: N; 0101 PL: ~N
  - 0110 VS: V; 0111 VC: ~V
  - 1000 HI: C&~Z; 1001 LS: ~(C&~Z)
  - 1010 GE: N==V; 1011 LT: N!=V
  - 1100 GT: ~Z&(N==V); 1101 LE: its inverse
  - 1110 AL: 1; 1111: 0 (never)
- `CondEx` = `InstrValid` & evaluated condition.
- Gated controls:
  - `PCSrc` = `PCS` & `CondEx`
  - `RegWrite` = `RegW` & `CondEx` & ~`NoWrite`
  - `MemWrite` = `MemW` & `CondEx`
- Flag update on the clock edge, only when `CondEx`=1:
  - `FlagW[1]` loads N,Z from `ALUFlags[3:2]`.
  - `FlagW[0]` loads C,V from `ALUFlags[1:0]`.
  - Each half updates independently; a half whose enable is 0 holds its value.
- Shadow register:
  - `FlagSave` copies the pre-edge `Flags` into the shadow.
  - `FlagRestore` loads the shadow into `Flags` and overrides any `FlagW` write in the same cycle.
  - `FlagSave` and `FlagRestore` together exchange `Flags` and the shadow.
- Skip counter:
  - Increments when `InstrValid`=1 and the condition fails.
  - Saturates at 2^CNT_W−1.
  - `CountClr` wins over a same-cycle increment.

## Timing
- `CondEx`, `PCSrc`, `RegWrite` and `MemWrite` are combinational from the inputs and stored flags, with zero latency.
- Flag, shadow and counter updates are visible one cycle after the edge. An instruction in the cycle after a flag-setting instruction sees the new flags; there is no same-cycle bypass.
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - `Flags`=0000, shadow=0000, `SkipCount`=0.
  - Gated outputs follow the combinational rules with flags=0000. EQ, CS, MI and VS fail; NE and AL pass.
- `InstrValid`=0 forces `CondEx`=0: no flag write, no count, and all gated outputs are 0.

## Structure
- Package `cond_pkg`:
  - Condition-code constants (`COND_EQ` … `COND_NV`).
  - Flag bit indices (`FLAG_N`=3, `FLAG_Z`=2, `FLAG_C`=1, `FLAG_V`=0).
  - `FLAGW_NZ`/`FLAGW_CV` bit positions.
- Sub-module `cond_check`: purely combinational, (`Cond`, `Flags`) → pass. Instantiated once. It is reused later by the pipelined datapath.
- The top level holds the flag register, shadow, counter and output gating.

## Test plan
- Reset mid-operation:
  - Setup: Flags=1111, shadow=1010, SkipCount=5; assert `reset`=0.
  - Response: immediately Flags=0000, shadow=0000, SkipCount=0.
  - Then `Cond`=0001 with `InstrValid`=1 → `CondEx`=1.
- Split flag write:
  - Setup: Flags=0000; `Cond`=1110, `FlagW`=10, `ALUFlags`=1111.
  - Response: next cycle Flags=1100.
  - Then `FlagW`=01, `ALUFlags`=0011 → Flags=1111.
- Failed condition:
  - Setup: Flags=0000; `Cond`=0000, `RegW`=`MemW`=`PCS`=1, `FlagW`=11, `ALUFlags`=1111.
  - Response: all gated outputs 0, Flags stay 0000, SkipCount 0→1.
- All 16 conditions:
  - Sweep every condition against every flag value (256 cases) and compare `CondEx` with the rule list.
  - Spot checks: Flags=1001 with GE → 1; Flags=0100 with LE → 1; Cond=1111 → 0.
- Shadow register:
  - Save at Flags=0110, write Flags=1001, then restore → Flags=0110.
  - Save+restore with Flags=0011, shadow=1100 → Flags=1100, shadow=0011.
  - Restore together with `FlagW`=11 → the restored value wins.
- Counter saturation:
  - 300 consecutive failed instructions → SkipCount=255.
  - `CountClr` with a failing instruction in the same cycle → 0.
